// File: rtl/hazard_sb.sv
// Hazard unit for the F/D/A/C/WB pipeline: forwarding, load-use, MUL scoreboard
// and a cache-miss freeze FSM. Pure control; no datapath values pass through.
package hazard_sb_pkg;
    typedef enum logic [1:0] {FROM_ALU = 2'd0, FROM_CACHE = 2'd1, FROM_PC4 = 2'd2} result_src_e;
    typedef enum logic       {PC_PLUS4 = 1'b0, FROM_A = 1'b1} pc_src_e;
    typedef enum logic [1:0] {NONE = 2'd0, FROM_C = 2'd1, FROM_WB = 2'd2} fwd_src_e;
endpackage

module hazard_sb
    import hazard_sb_pkg::*;
#(
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned MUL_LAT  = 4
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [REG_BITS-1:0] rs1_D_in,
    input  logic [REG_BITS-1:0] rs2_D_in,
    input  logic [REG_BITS-1:0] rd_D_in,
    input  logic                reg_write_D_in,
    input  logic                is_mul_D_in,
    input  logic [REG_BITS-1:0] rs1_A_in,
    input  logic [REG_BITS-1:0] rs2_A_in,
    input  logic [REG_BITS-1:0] rd_A_in,
    input  result_src_e         result_src_A_in,
    input  logic [REG_BITS-1:0] rd_C_in,
    input  logic [REG_BITS-1:0] rd_WB_in,
    input  logic                reg_write_C_in,
    input  logic                reg_write_WB_in,
    input  pc_src_e             pc_src_in,
    input  logic                icache_miss_in,
    input  logic                icache_ready_in,
    input  logic                dcache_miss_in,
    input  logic                dcache_ready_in,
    output fwd_src_e            fwd_src1_out,
    output fwd_src_e            fwd_src2_out,
    output logic                stall_F_out,
    output logic                stall_D_out,
    output logic                stall_A_out,
    output logic                stall_C_out,
    output logic                flush_D_out,
    output logic                flush_A_out,
    output logic                flush_WB_out,
    output logic [NUM_REGS-1:0] sb_busy_out
);
    localparam int unsigned CNT_BITS = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DMISS = 2'd1, IMISS = 2'd2} state_e;

    state_e              state_q, state_d;
    logic                imiss_pend_q, imiss_pend_d;
    logic [CNT_BITS-1:0] cnt [NUM_REGS];
    logic                lu, sb_hit, hz, branch, issue;

    // Operand forwarding into A; C is younger than WB so it wins.
    always_comb begin
        fwd_src1_out = NONE;
        fwd_src2_out = NONE;
        if (rs1_A_in != '0 && reg_write_C_in && rs1_A_in == rd_C_in)
            fwd_src1_out = FROM_C;
        else if (rs1_A_in != '0 && reg_write_WB_in && rs1_A_in == rd_WB_in)
            fwd_src1_out = FROM_WB;
        if (rs2_A_in != '0 && reg_write_C_in && rs2_A_in == rd_C_in)
            fwd_src2_out = FROM_C;
        else if (rs2_A_in != '0 && reg_write_WB_in && rs2_A_in == rd_WB_in)
            fwd_src2_out = FROM_WB;
    end

    always_comb begin
        sb_busy_out = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++)
            sb_busy_out[r] = (cnt[r] != '0);
    end

    always_comb begin
        lu = (result_src_A_in == FROM_CACHE) && (rd_A_in != '0) &&
             (rs1_D_in == rd_A_in || rs2_D_in == rd_A_in);
        sb_hit = (rs1_D_in != '0 && sb_busy_out[rs1_D_in]) ||
                 (rs2_D_in != '0 && sb_busy_out[rs2_D_in]) ||
                 (reg_write_D_in && rd_D_in != '0 && sb_busy_out[rd_D_in]);
        hz     = lu || sb_hit;
        branch = (pc_src_in == FROM_A);
    end

    // Stall/flush decode; a frozen D-miss overrides everything including branches.
    always_comb begin
        stall_F_out  = 1'b0;
        stall_D_out  = 1'b0;
        stall_A_out  = 1'b0;
        stall_C_out  = 1'b0;
        flush_D_out  = 1'b0;
        flush_A_out  = 1'b0;
        flush_WB_out = 1'b0;
        if (state_q == DMISS) begin
            stall_F_out  = 1'b1;
            stall_D_out  = 1'b1;
            stall_A_out  = 1'b1;
            stall_C_out  = 1'b1;
            flush_WB_out = 1'b1;
        end else begin
            stall_F_out = (state_q == IMISS) || hz;
            stall_D_out = hz;
            flush_A_out = hz;
            flush_D_out = (state_q == IMISS);
            if (branch) begin
                stall_F_out = 1'b0;
                flush_D_out = 1'b1;
                flush_A_out = 1'b1;
            end
            if (flush_D_out)
                stall_D_out = 1'b0;
        end
    end

    // A MUL leaves D only when D is not held and is not turned into a bubble in A.
    always_comb begin
        issue = is_mul_D_in && reg_write_D_in && (rd_D_in != '0) &&
                !stall_D_out && !flush_A_out;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (issue && rd_D_in == REG_BITS'(r))
                    cnt[r] <= CNT_BITS'(MUL_LAT);
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            imiss_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            imiss_pend_q <= imiss_pend_d;
        end
    end

    // Miss sequencing; an I-miss seen while D is frozen is replayed after the refill.
    always_comb begin
        state_d      = state_q;
        imiss_pend_d = imiss_pend_q;
        case (state_q)
            IDLE: begin
                if (dcache_miss_in) begin
                    state_d      = DMISS;
                    imiss_pend_d = icache_miss_in;
                end else if (icache_miss_in) begin
                    state_d = IMISS;
                end
            end
            DMISS: begin
                if (dcache_ready_in) begin
                    state_d      = (imiss_pend_q || icache_miss_in) ? IMISS : IDLE;
                    imiss_pend_d = 1'b0;
                end else if (icache_miss_in) begin
                    imiss_pend_d = 1'b1;
                end
            end
            IMISS: begin
                if (dcache_miss_in) begin
                    state_d      = DMISS;
                    imiss_pend_d = !icache_ready_in;
                end else if (icache_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: directed vector table, multi-cycle scenarios,
// then randomized traffic against a behavioural reference model.
module tb_hazard_sb;
    import hazard_sb_pkg::*;

    localparam int MUL_LAT = 4;

    logic        clk, rst_n;
    logic [4:0]  rs1_d, rs2_d, rd_d, rs1_a, rs2_a, rd_a, rd_c, rd_wb;
    logic        rw_d, mul_d, rw_c, rw_wb;
    result_src_e res_a;
    pc_src_e     pc_src;
    logic        imiss, iready, dmiss, dready;
    fwd_src_e    fwd1, fwd2;
    logic        s_f, s_d, s_a, s_c, f_d, f_a, f_wb;
    logic [31:0] busy;

    int errors = 0;
    int checks = 0;

    hazard_sb dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .rs1_D_in(rs1_d), .rs2_D_in(rs2_d), .rd_D_in(rd_d),
        .reg_write_D_in(rw_d), .is_mul_D_in(mul_d),
        .rs1_A_in(rs1_a), .rs2_A_in(rs2_a), .rd_A_in(rd_a),
        .result_src_A_in(res_a),
        .rd_C_in(rd_c), .rd_WB_in(rd_wb),
        .reg_write_C_in(rw_c), .reg_write_WB_in(rw_wb),
        .pc_src_in(pc_src),
        .icache_miss_in(imiss), .icache_ready_in(iready),
        .dcache_miss_in(dmiss), .dcache_ready_in(dready),
        .fwd_src1_out(fwd1), .fwd_src2_out(fwd2),
        .stall_F_out(s_f), .stall_D_out(s_d), .stall_A_out(s_a), .stall_C_out(s_c),
        .flush_D_out(f_d), .flush_A_out(f_a), .flush_WB_out(f_wb),
        .sb_busy_out(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1_a, rs2_a, rd_a, rs1_d, rs2_d, rd_c, rd_wb;
        logic        rw_c, rw_wb;
        result_src_e res;
        pc_src_e     pc;
        fwd_src_e    e_f1, e_f2;
        logic [6:0]  e_ctl;
    } vec_t;

    localparam logic [6:0] CTL_DMISS = 7'b1111001;
    localparam logic [6:0] CTL_IMISS = 7'b1000100;
    localparam logic [6:0] CTL_LU    = 7'b1100010;
    localparam logic [6:0] CTL_BR    = 7'b0000110;

    function automatic vec_t mk(input logic [4:0] r1a, r2a, rda, r1d, r2d, rdc, rdwb,
                                input logic wc, ww, input result_src_e rs, input pc_src_e pc,
                                input fwd_src_e f1, f2, input logic [6:0] ctl);
        vec_t v;
        v.rs1_a = r1a; v.rs2_a = r2a; v.rd_a = rda; v.rs1_d = r1d; v.rs2_d = r2d;
        v.rd_c = rdc; v.rd_wb = rdwb; v.rw_c = wc; v.rw_wb = ww; v.res = rs; v.pc = pc;
        v.e_f1 = f1; v.e_f2 = f2; v.e_ctl = ctl;
        return v;
    endfunction

    function automatic logic [6:0] ctl();
        return {s_f, s_d, s_a, s_c, f_d, f_a, f_wb};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        rs1_d = '0; rs2_d = '0; rd_d = '0; rw_d = 1'b0; mul_d = 1'b0;
        rs1_a = '0; rs2_a = '0; rd_a = '0; res_a = FROM_ALU;
        rd_c = '0; rd_wb = '0; rw_c = 1'b0; rw_wb = 1'b0; pc_src = PC_PLUS4;
        imiss = 1'b0; iready = 1'b0; dmiss = 1'b0; dready = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        idle_in();
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        cyc();
    endtask

    // Reference model state: remaining MUL cycles per register and miss mode.
    int m_left [32];
    int m_mode;          // 0 running, 1 waiting D refill, 2 waiting I refill
    bit m_ipend;

    task automatic model_step();
        fwd_src_e   e1, e2;
        bit         luse, busyhit, hzd, br, frozen, iss;
        logic [6:0] ectl;
        logic [31:0] ebusy;
        bit esf, esd, efd, efa;
        e1 = NONE; e2 = NONE;
        if (rs1_a != 0 && rw_c && rs1_a == rd_c) e1 = FROM_C;
        else if (rs1_a != 0 && rw_wb && rs1_a == rd_wb) e1 = FROM_WB;
        if (rs2_a != 0 && rw_c && rs2_a == rd_c) e2 = FROM_C;
        else if (rs2_a != 0 && rw_wb && rs2_a == rd_wb) e2 = FROM_WB;
        ebusy = '0;
        for (int r = 0; r < 32; r++) ebusy[r] = (m_left[r] > 0);
        luse = (res_a == FROM_CACHE) && rd_a != 0 && (rs1_d == rd_a || rs2_d == rd_a);
        busyhit = (rs1_d != 0 && m_left[rs1_d] > 0) || (rs2_d != 0 && m_left[rs2_d] > 0) ||
                  (rw_d && rd_d != 0 && m_left[rd_d] > 0);
        hzd = luse || busyhit;
        br = (pc_src == FROM_A);
        frozen = (m_mode == 1);
        if (frozen) begin
            ectl = CTL_DMISS;
            esd = 1'b1; efa = 1'b0;
        end else begin
            esf = hzd || (m_mode == 2);
            efd = (m_mode == 2);
            efa = hzd;
            if (br) begin esf = 0; efd = 1; efa = 1; end
            esd = hzd && !efd;
            ectl = {esf, esd, 1'b0, 1'b0, efd, efa, 1'b0};
        end
        chk("rand", {21'd0, fwd1, fwd2, ctl(), busy}, {21'd0, e1, e2, ectl, ebusy});
        iss = mul_d && rw_d && rd_d != 0 && !esd && !efa;
        for (int r = 0; r < 32; r++) begin
            if (iss && r == int'(rd_d)) m_left[r] = MUL_LAT;
            else if (m_left[r] > 0) m_left[r]--;
        end
        if (m_mode == 0) begin
            if (dmiss) begin m_mode = 1; m_ipend = imiss; end
            else if (imiss) m_mode = 2;
        end else if (m_mode == 1) begin
            if (dready) begin m_mode = (m_ipend || imiss) ? 2 : 0; m_ipend = 0; end
            else if (imiss) m_ipend = 1;
        end else begin
            if (dmiss) begin m_mode = 1; m_ipend = !iready; end
            else if (iready) m_mode = 0;
        end
    endtask

    vec_t vecs [13];

    initial begin
        idle_in();
        rst_n = 1'b0;
        #12;
        chk("rst_ctl", 64'(ctl()), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fwd", 64'({fwd1, fwd2}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FROM_ALU, PC_PLUS4, NONE, NONE, 7'd0);
        vecs[1]  = mk(3, 0, 0, 0, 0, 3, 0, 1, 0, FROM_ALU, PC_PLUS4, FROM_C, NONE, 7'd0);
        vecs[2]  = mk(0, 4, 0, 0, 0, 0, 4, 0, 1, FROM_ALU, PC_PLUS4, NONE, FROM_WB, 7'd0);
        vecs[3]  = mk(6, 0, 0, 0, 0, 6, 6, 1, 1, FROM_ALU, PC_PLUS4, FROM_C, NONE, 7'd0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, FROM_ALU, PC_PLUS4, NONE, NONE, 7'd0);
        vecs[5]  = mk(9, 0, 0, 0, 0, 9, 0, 0, 0, FROM_ALU, PC_PLUS4, NONE, NONE, 7'd0);
        vecs[6]  = mk(0, 0, 5, 5, 1, 0, 0, 0, 0, FROM_CACHE, PC_PLUS4, NONE, NONE, CTL_LU);
        vecs[7]  = mk(0, 0, 5, 1, 5, 0, 0, 0, 0, FROM_CACHE, PC_PLUS4, NONE, NONE, CTL_LU);
        vecs[8]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, FROM_CACHE, PC_PLUS4, NONE, NONE, 7'd0);
        vecs[9]  = mk(0, 0, 5, 5, 1, 0, 0, 0, 0, FROM_ALU, PC_PLUS4, NONE, NONE, 7'd0);
        vecs[10] = mk(0, 0, 5, 5, 1, 0, 0, 0, 0, FROM_CACHE, FROM_A, NONE, NONE, CTL_BR);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FROM_ALU, FROM_A, NONE, NONE, CTL_BR);
        vecs[12] = mk(7, 7, 0, 0, 0, 7, 2, 1, 1, FROM_ALU, PC_PLUS4, FROM_C, FROM_C, 7'd0);

        for (int i = 0; i < 13; i++) begin
            idle_in();
            rs1_a = vecs[i].rs1_a; rs2_a = vecs[i].rs2_a; rd_a = vecs[i].rd_a;
            rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d; rd_c = vecs[i].rd_c;
            rd_wb = vecs[i].rd_wb; rw_c = vecs[i].rw_c; rw_wb = vecs[i].rw_wb;
            res_a = vecs[i].res; pc_src = vecs[i].pc;
            settle();
            chk($sformatf("vec%0d_fwd", i), 64'({fwd1, fwd2}), 64'({vecs[i].e_f1, vecs[i].e_f2}));
            chk($sformatf("vec%0d_ctl", i), 64'(ctl()), 64'(vecs[i].e_ctl));
            cyc();
        end

        // RAW then WAW behind a MUL to x7
        for (int w = 0; w < 2; w++) begin
            idle_in();
            mul_d = 1'b1; rw_d = 1'b1; rd_d = 5'd7;
            settle();
            chk("mul_issue_ctl", 64'(ctl()), 64'd0);
            cyc();
            idle_in();
            rw_d = 1'b1;
            if (w == 0) begin rd_d = 5'd8; rs1_d = 5'd7; rs2_d = 5'd7; end
            else rd_d = 5'd7;
            for (int k = 0; k <= MUL_LAT; k++) begin
                settle();
                chk($sformatf("mul%0d_stallD_k%0d", w, k), 64'(s_d), 64'(k < MUL_LAT));
                chk($sformatf("mul%0d_busy7_k%0d", w, k), 64'(busy[7]), 64'(k < MUL_LAT));
                cyc();
            end
        end

        // D-miss for 10 cycles while a MUL to x3 counts down
        idle_in();
        mul_d = 1'b1; rw_d = 1'b1; rd_d = 5'd3; dmiss = 1'b1;
        settle();
        chk("dmiss_t_ctl", 64'(ctl()), 64'd0);
        cyc();
        idle_in();
        for (int i = 1; i <= 10; i++) begin
            dready = (i == 10);
            settle();
            chk($sformatf("dmiss_ctl_%0d", i), 64'(ctl()), 64'(CTL_DMISS));
            chk($sformatf("dmiss_busy3_%0d", i), 64'(busy[3]), 64'(i <= MUL_LAT));
            cyc();
        end
        idle_in();
        settle();
        chk("dmiss_release", 64'(ctl()), 64'd0);
        cyc();

        // I-miss arriving during D-miss is serviced after the D refill
        dmiss = 1'b1;
        cyc();
        idle_in();
        for (int i = 1; i <= 5; i++) begin
            imiss = (i == 3);
            dready = (i == 5);
            settle();
            chk($sformatf("dpend_ctl_%0d", i), 64'(ctl()), 64'(CTL_DMISS));
            cyc();
        end
        idle_in();
        for (int i = 0; i < 3; i++) begin
            iready = (i == 2);
            settle();
            chk($sformatf("imiss_ctl_%0d", i), 64'(ctl()), 64'(CTL_IMISS));
            cyc();
        end
        idle_in();
        settle();
        chk("imiss_release", 64'(ctl()), 64'd0);
        cyc();

        // Branch is frozen during a D-miss and takes effect after release
        dmiss = 1'b1;
        cyc();
        idle_in();
        pc_src = FROM_A; res_a = FROM_CACHE; rd_a = 5'd5; rs1_d = 5'd5; dready = 1'b1;
        settle();
        chk("br_in_dmiss", 64'(ctl()), 64'(CTL_DMISS));
        cyc();
        dready = 1'b0;
        settle();
        chk("br_after_release", 64'(ctl()), 64'(CTL_BR));
        cyc();

        // Reset while frozen with a MUL in flight
        idle_in();
        mul_d = 1'b1; rw_d = 1'b1; rd_d = 5'd3; dmiss = 1'b1;
        cyc();
        idle_in();
        cyc();
        cyc();
        settle();
        chk("pre_rst_busy3", 64'(busy[3]), 64'd1);
        chk("pre_rst_ctl", 64'(ctl()), 64'(CTL_DMISS));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 64'(ctl()), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        settle();
        chk("post_rst_ctl", 64'(ctl()), 64'd0);

        // Randomized traffic against the reference model
        do_reset();
        for (int r = 0; r < 32; r++) m_left[r] = 0;
        m_mode = 0;
        m_ipend = 0;
        for (int n = 0; n < 600; n++) begin
            rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
            rd_d  = 5'($urandom_range(0, 7)); rw_d = ($urandom_range(0, 3) != 0);
            mul_d = ($urandom_range(0, 3) == 0);
            rs1_a = 5'($urandom_range(0, 7)); rs2_a = 5'($urandom_range(0, 7));
            rd_a  = 5'($urandom_range(0, 7)); res_a = result_src_e'(2'($urandom_range(0, 2)));
            rd_c  = 5'($urandom_range(0, 7)); rd_wb = 5'($urandom_range(0, 7));
            rw_c  = 1'($urandom_range(0, 1)); rw_wb = 1'($urandom_range(0, 1));
            pc_src = ($urandom_range(0, 7) == 0) ? FROM_A : PC_PLUS4;
            dmiss  = ($urandom_range(0, 19) == 0);
            dready = ($urandom_range(0, 5) == 0);
            imiss  = ($urandom_range(0, 14) == 0);
            iready = ($urandom_range(0, 4) == 0);
            settle();
            model_step();
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
